// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester front end for a single-port register file with
// a registered address/data/write-enable interface and an asynchronous read.
// One transaction is in flight at a time: IDLE -> ISSUE -> RESP -> IDLE(ack).
// In the cycle an ack is high no new grant is made, so a held request is
// re-arbitrated only in the following IDLE cycle.
// Build macro REGFILE_ARB_RR_EN: when defined, contested arbitration is
// round-robin; when undefined, requester 0 always wins and no pointer exists.

`ifndef ADDR_W
`define ADDR_W 4
`endif
`ifndef DATA_W
`define DATA_W 8
`endif
`ifndef ENABLE_
`define ENABLE_ 1'b0
`endif
`ifndef DISABLE_
`define DISABLE_ 1'b1
`endif

module regfile_arbiter #(
    parameter int unsigned ADDR_W = `ADDR_W,
    parameter int unsigned DATA_W = `DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic              we0_,
    input  logic              we1_,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              rf_we_,
    input  logic [DATA_W-1:0] rf_d_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              grant_nxt;
    logic              win;
    logic [1:0]        ack_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [ADDR_W-1:0] rf_addr_nxt;
    logic [DATA_W-1:0] rf_d_in_nxt;
    logic              rf_we_nxt;

`ifdef REGFILE_ARB_RR_EN
    logic              prio;
    logic              prio_nxt;

    // Winner select: pointer breaks ties, a lone request always wins
    always_comb begin
        win = (req == 2'b11) ? prio : req[1];
    end
`else
    // Winner select: requester 0 wins whenever it is requesting
    always_comb begin
        win = ~req[0];
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        ack_nxt     = 2'b00;
        rdata_nxt   = rdata;
        rf_addr_nxt = rf_addr;
        rf_d_in_nxt = rf_d_in;
        rf_we_nxt   = `DISABLE_;
`ifdef REGFILE_ARB_RR_EN
        prio_nxt    = prio;
`endif
        case (state)
            IDLE: begin
                // No grant while an ack is out: the acked requester may still
                // be holding its request this cycle.
                if ((|req) && (ack == 2'b00)) begin
                    grant_nxt   = win;
                    rf_addr_nxt = win ? addr1 : addr0;
                    rf_d_in_nxt = win ? wdata1 : wdata0;
                    rf_we_nxt   = win ? we1_ : we0_;
                    state_nxt   = ISSUE;
`ifdef REGFILE_ARB_RR_EN
                    prio_nxt    = ~win;
`endif
                end
            end
            ISSUE: begin
                // Write (if any) commits at the end of this cycle
                state_nxt = RESP;
            end
            RESP: begin
                // Async read now reflects any write just committed
                rdata_nxt = rf_d_out;
                ack_nxt   = grant ? 2'b10 : 2'b01;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            ack     <= 2'b00;
            rdata   <= '0;
            rf_addr <= '0;
            rf_d_in <= '0;
            rf_we_  <= `DISABLE_;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            ack     <= ack_nxt;
            rdata   <= rdata_nxt;
            rf_addr <= rf_addr_nxt;
            rf_d_in <= rf_d_in_nxt;
            rf_we_  <= rf_we_nxt;
        end
    end

`ifdef REGFILE_ARB_RR_EN
    // Round-robin pointer, requester 0 favoured out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else begin
            prio <= prio_nxt;
        end
    end
`endif

endmodule
